logic2048_single_line: RTL and testbench

Registered move/merge engine for one 4-cell row of the 2048 game. Cells hold 4-bit exponent codes: 0 means empty, and n means tile 2^n. Each accepted line is slid toward cell 0 and merged using standard 2048 rules. The block sits under the board controller, which issues one row or column per cycle, already oriented so that the move direction points toward index 0.

---
 rtl/logic2048_single_line.sv | 121 ++++++++++++
 tb/tb_logic2048_single_line.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/logic2048_single_line.sv
// One-row 2048 move/merge engine: compacts a 4-cell line toward cell 0, merges equal
// neighbours once per move, and registers the result with a one-cycle latency.
module logic2048_single_line (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  input  logic [3:0] x3,
  output logic       out_valid,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic       moved,
  output logic [1:0] merge_count,
  output logic       saturated
);

  logic [3:0][3:0] x_in;
  logic [3:0][3:0] comp;
  logic [3:0][3:0] res;
  logic [2:0]      cpos;
  logic [2:0]      rpos;
  logic [3:0]      pair_eq;
  logic            skip;
  logic [1:0]      mc;
  logic            sat;

  logic            out_valid_d, out_valid_q;
  logic [3:0][3:0] y_d, y_q;
  logic            moved_d, moved_q;
  logic [1:0]      merge_count_d, merge_count_q;
  logic            saturated_d, saturated_q;

  assign x_in = {x3, x2, x1, x0};

  // Slide nonzero tiles toward cell 0, preserving order.
  always_comb begin
    comp = '0;
    cpos = '0;
    for (int i = 0; i < 4; i++) begin
      if (x_in[i] != 4'd0) begin
        comp[cpos[1:0]] = x_in[i];
        cpos            = cpos + 3'd1;
      end
    end
  end

  // Merge scan from cell 0; a merged pair consumes both tiles so results never re-merge.
  always_comb begin
    pair_eq[0] = (comp[0] != 4'd0) && (comp[0] == comp[1]);
    pair_eq[1] = (comp[1] != 4'd0) && (comp[1] == comp[2]);
    pair_eq[2] = (comp[2] != 4'd0) && (comp[2] == comp[3]);
    pair_eq[3] = 1'b0;
    res  = '0;
    rpos = '0;
    skip = 1'b0;
    mc   = '0;
    sat  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (pair_eq[i]) begin
        if (comp[i] == 4'd15) begin
          res[rpos[1:0]] = 4'd15;
          sat            = 1'b1;
        end else begin
          res[rpos[1:0]] = comp[i] + 4'd1;
        end
        rpos = rpos + 3'd1;
        mc   = mc + 2'd1;
        skip = 1'b1;
      end else begin
        res[rpos[1:0]] = comp[i];
        rpos           = rpos + 3'd1;
      end
    end
  end

  always_comb begin
    out_valid_d   = in_valid;
    y_d           = y_q;
    moved_d       = moved_q;
    merge_count_d = merge_count_q;
    saturated_d   = saturated_q;
    if (in_valid) begin
      y_d           = res;
      moved_d       = (res != x_in);
      merge_count_d = mc;
      saturated_d   = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      y_q           <= '0;
      moved_q       <= 1'b0;
      merge_count_q <= '0;
      saturated_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      y_q           <= y_d;
      moved_q       <= moved_d;
      merge_count_q <= merge_count_d;
      saturated_q   <= saturated_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign moved       = moved_q;
  assign merge_count = merge_count_q;
  assign saturated   = saturated_q;

endmodule

// File: tb/tb_logic2048_single_line.sv
// Self-checking bench for logic2048_single_line: directed rows then random rows,
// compared against a queue-based model of the 2048 row rules.
module tb_logic2048_single_line;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x0, x1, x2, x3;
  logic       out_valid;
  logic [3:0] y0, y1, y2, y3;
  logic       moved;
  logic [1:0] merge_count;
  logic       saturated;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  int unsigned e_y[4];
  int unsigned e_valid, e_moved, e_mc, e_sat;

  always #5 clk = ~clk;

  logic2048_single_line dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .x0          (x0),
    .x1          (x1),
    .x2          (x2),
    .x3          (x3),
    .out_valid   (out_valid),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .moved       (moved),
    .merge_count (merge_count),
    .saturated   (saturated)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Play the row as a list of tiles: drop empties, then pair equal neighbours front to back.
  task automatic model(input int unsigned a, input int unsigned b,
                       input int unsigned c, input int unsigned d);
    int unsigned tiles[$];
    int unsigned outq[$];
    int unsigned xin[4];
    int unsigned k;
    xin = '{a, b, c, d};
    foreach (xin[i]) if (xin[i] != 0) tiles.push_back(xin[i]);
    e_mc  = 0;
    e_sat = 0;
    k = 0;
    while (k < tiles.size()) begin
      if (k + 1 < tiles.size() && tiles[k] == tiles[k+1]) begin
        if (tiles[k] == 15) begin
          outq.push_back(15);
          e_sat = 1;
        end else begin
          outq.push_back(tiles[k] + 1);
        end
        e_mc++;
        k += 2;
      end else begin
        outq.push_back(tiles[k]);
        k += 1;
      end
    end
    while (outq.size() < 4) outq.push_back(0);
    e_moved = 0;
    for (int i = 0; i < 4; i++) begin
      e_y[i] = outq[i];
      if (outq[i] != xin[i]) e_moved = 1;
    end
  endtask

  task automatic step(input logic r, input logic v, input int unsigned a, input int unsigned b,
                      input int unsigned c, input int unsigned d, input string tag);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    x0 = a[3:0]; x1 = b[3:0]; x2 = c[3:0]; x3 = d[3:0];
    if (r) begin
      e_y = '{0, 0, 0, 0};
      e_valid = 0; e_moved = 0; e_mc = 0; e_sat = 0;
    end else if (v) begin
      model(a, b, c, d);
      e_valid = 1;
    end else begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, out_valid, e_valid);
    check({tag, ".y0"}, y0, e_y[0]);
    check({tag, ".y1"}, y1, e_y[1]);
    check({tag, ".y2"}, y2, e_y[2]);
    check({tag, ".y3"}, y3, e_y[3]);
    check({tag, ".moved"}, moved, e_moved);
    check({tag, ".merge_count"}, merge_count, e_mc);
    check({tag, ".saturated"}, saturated, e_sat);
  endtask

  initial begin
    int unsigned r[4];
    rst = 1'b1; in_valid = 1'b0; x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    step(1, 1, 3, 3, 0, 0, "reset_discard");
    step(0, 1, 0, 1, 2, 0, "slide");
    step(0, 1, 1, 1, 2, 0, "b2b_a");
    step(0, 1, 1, 1, 1, 0, "b2b_b");
    step(0, 1, 0, 0, 0, 1, "b2b_c");
    step(0, 1, 2, 1, 0, 1, "no_remerge");
    step(0, 1, 1, 1, 1, 1, "double_1");
    step(0, 1, 2, 2, 2, 2, "double_2");
    step(0, 1, 1, 2, 3, 4, "unmoved");
    step(0, 1, 0, 0, 0, 0, "empty");
    step(0, 1, 15, 15, 4, 0, "saturate");
    step(0, 0, 1, 1, 1, 1, "hold");
    step(0, 1, 7, 0, 7, 7, "mid_pair");
    step(0, 0, 0, 0, 0, 0, "hold2");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0:       r[i] = 15;
          1:       r[i] = $urandom_range(0, 15);
          default: r[i] = $urandom_range(0, 3);
        endcase
      end
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0),
           r[0], r[1], r[2], r[3], "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
